// File: rtl/mux4_rr_scheduler.sv
// Round-robin owner scheduler for a 4-to-1, W-bit selection datapath with bounded dwell and a guard cycle.
// Optional build macro: MUX_SCHED_FIXED_PRI_EN selects fixed U>V>W>X priority instead of round-robin.
module mux4_rr_scheduler #(
  parameter int W           = 2,
  parameter int HOLD_CYCLES = 8
) (
  input  logic           Clock,
  input  logic           Resetn,
  input  logic [3:0]     req,
  input  logic [4*W-1:0] din,
  output logic [3:0]     grant,
  output logic [1:0]     sel,
  output logic [W-1:0]   m_out,
  output logic           m_valid,
  output logic           busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  localparam logic [7:0] CNT_MAX = 8'(HOLD_CYCLES - 1);

  state_t         state_r, state_s;
  logic [3:0]     req_r;
  logic [3:0]     grant_r, grant_s;
  logic [1:0]     sel_r, sel_s;
  logic [7:0]     cnt_r, cnt_s;
  logic [W-1:0]   m_out_r, m_out_s;
  logic           m_valid_r, m_valid_s;
  logic           busy_r, busy_s;
  logic [1:0]     win_s;
  logic           others_s;
  logic           start_s;

  assign start_s  = (state_r == ST_IDLE) && (req_r != 4'b0000);
  assign others_s = |(req_r & ~grant_r);

`ifdef MUX_SCHED_FIXED_PRI_EN
  function automatic logic [1:0] fixed_pick(input logic [3:0] r);
    logic [1:0] win;
    win = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (r[i]) begin
        win = 2'(i);
      end else begin
        win = win;
      end
    end
    return win;
  endfunction

  assign win_s = fixed_pick(req_r);
`else
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = ptr;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && r[idx]) begin
        win   = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return win;
  endfunction

  logic [1:0] ptr_r, ptr_s;

  assign win_s = rr_pick(req_r, ptr_r);

  // Pointer moves to the winner at the moment the grant is issued
  always_comb begin
    ptr_s = ptr_r;
    if (start_s) begin
      ptr_s = win_s;
    end else begin
      ptr_s = ptr_r;
    end
  end

  // Round-robin pointer register; reset value lets U win first contention
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      ptr_r <= 2'd3;
    end else begin
      ptr_r <= ptr_s;
    end
  end
`endif

  // Next-state and next-output logic; outputs are computed for the upcoming state
  always_comb begin
    state_s   = state_r;
    grant_s   = grant_r;
    sel_s     = sel_r;
    cnt_s     = cnt_r;
    m_out_s   = m_out_r;
    m_valid_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_s = ST_GRANT;
          grant_s = 4'b0001 << win_s;
          sel_s   = win_s;
          cnt_s   = 8'd0;
        end else begin
          state_s = ST_IDLE;
          grant_s = 4'b0000;
        end
      end
      ST_GRANT: begin
        if (!req_r[sel_r] || ((cnt_r == CNT_MAX) && others_s)) begin
          state_s = ST_GUARD;
          grant_s = 4'b0000;
        end else begin
          state_s   = ST_GRANT;
          m_out_s   = din[int'(sel_r)*W +: W];
          m_valid_s = 1'b1;
          if (cnt_r != CNT_MAX) begin
            cnt_s = cnt_r + 8'd1;
          end else begin
            cnt_s = cnt_r;
          end
        end
      end
      ST_GUARD: begin
        state_s = ST_IDLE;
        grant_s = 4'b0000;
      end
      default: begin
        state_s = ST_IDLE;
        grant_s = 4'b0000;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // Request capture stage keeps req off every output path
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      req_r <= 4'b0000;
    end else begin
      req_r <= req;
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_r   <= ST_IDLE;
      grant_r   <= 4'b0000;
      sel_r     <= 2'd0;
      cnt_r     <= 8'd0;
      m_out_r   <= '0;
      m_valid_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      grant_r   <= grant_s;
      sel_r     <= sel_s;
      cnt_r     <= cnt_s;
      m_out_r   <= m_out_s;
      m_valid_r <= m_valid_s;
      busy_r    <= busy_s;
    end
  end

  assign grant   = grant_r;
  assign sel     = sel_r;
  assign m_out   = m_out_r;
  assign m_valid = m_valid_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_mux4_rr_scheduler.sv
// Directed bench for mux4_rr_scheduler: default instance (HOLD_CYCLES=8) plus a HOLD_CYCLES=1 instance.
module tb_mux4_rr_scheduler;

  localparam int W = 2;
`ifdef MUX_SCHED_FIXED_PRI_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic           Clock = 1'b0;
  logic           Resetn;
  logic [3:0]     req;
  logic [4*W-1:0] din;
  logic [3:0]     grant, grant1;
  logic [1:0]     sel, sel1;
  logic [W-1:0]   m_out, m_out1;
  logic           m_valid, m_valid1;
  logic           busy, busy1;

  int tests = 0;
  int fails = 0;

  mux4_rr_scheduler #(.W(W), .HOLD_CYCLES(8)) dut (
    .Clock(Clock), .Resetn(Resetn), .req(req), .din(din),
    .grant(grant), .sel(sel), .m_out(m_out), .m_valid(m_valid), .busy(busy)
  );

  mux4_rr_scheduler #(.W(W), .HOLD_CYCLES(1)) dut1 (
    .Clock(Clock), .Resetn(Resetn), .req(req), .din(din),
    .grant(grant1), .sel(sel1), .m_out(m_out1), .m_valid(m_valid1), .busy(busy1)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    req    = 4'b0000;
    tick();
    tick();
    Resetn = 1'b1;
    tick();
  endtask

  initial begin
    logic [7:0] dpat;
    logic [3:0] exp_g;
    int         owner;

    Resetn = 1'b0;
    req    = 4'b0000;
    din    = '0;
    tick();
    tick();
    Resetn = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_grant", 32'(grant), 32'd0);
      check("idle_sel", 32'(sel), 32'd0);
      check("idle_mvalid", 32'(m_valid), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_mout", 32'(m_out), 32'd0);
    end

    // Single requester W, then drop
    din = 8'b00_10_00_00;
    req = 4'b0100;
    tick();
    check("w_pre_grant", 32'(grant), 32'd0);
    tick();
    check("w_grant", 32'(grant), 32'b0100);
    check("w_sel", 32'(sel), 32'd2);
    check("w_mvalid_first", 32'(m_valid), 32'd0);
    check("w_busy", 32'(busy), 32'd1);
    tick();
    check("w_mout", 32'(m_out), 32'b10);
    check("w_mvalid", 32'(m_valid), 32'd1);
    req = 4'b0000;
    tick();
    check("w_still_grant", 32'(grant), 32'b0100);
    tick();
    check("w_guard_grant", 32'(grant), 32'd0);
    check("w_guard_mvalid", 32'(m_valid), 32'd0);
    check("w_guard_busy", 32'(busy), 32'd1);
    check("w_guard_mout", 32'(m_out), 32'b10);
    tick();
    check("w_idle_busy", 32'(busy), 32'd0);
    check("w_idle_grant", 32'(grant), 32'd0);

    // All four requesting: rotation with 8-cycle dwell and 2-cycle gap
    do_reset();
    dpat = 8'b00_11_10_01;
    din  = dpat;
    req  = 4'b1111;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      owner = FIXED ? 0 : (k % 4);
      exp_g = 4'b0001 << owner;
      check("rot_grant_first", 32'(grant), 32'(exp_g));
      check("rot_sel", 32'(sel), 32'(owner));
      repeat (7) tick();
      check("rot_grant_last", 32'(grant), 32'(exp_g));
      check("rot_mvalid", 32'(m_valid), 32'd1);
      check("rot_mout", 32'(m_out), 32'(dpat[owner*2 +: 2]));
      tick();
      check("rot_guard_grant", 32'(grant), 32'd0);
      check("rot_guard_mvalid", 32'(m_valid), 32'd0);
      check("rot_guard_busy", 32'(busy), 32'd1);
      tick();
      check("rot_idle_grant", 32'(grant), 32'd0);
      check("rot_idle_busy", 32'(busy), 32'd0);
      tick();
    end

    // Lone V keeps grant; X arriving forces release after saturated dwell
    do_reset();
    req = 4'b0010;
    tick();
    tick();
    for (int i = 0; i < 50; i++) begin
      check("v_hold", 32'(grant), 32'b0010);
      tick();
    end
    req = 4'b1010;
    check("v_hold_end", 32'(grant), 32'b0010);
    tick();
    check("v_before_release", 32'(grant), 32'b0010);
    tick();
    check("v_guard", 32'(grant), 32'd0);
    check("v_guard_mvalid", 32'(m_valid), 32'd0);
    tick();
    check("v_idle", 32'(grant), 32'd0);
    tick();
    exp_g = FIXED ? 4'b0010 : 4'b1000;
    check("x_grant", 32'(grant), 32'(exp_g));

    // Owner drops in the same cycle W rises
    req = 4'b0100;
    tick();
    check("drop_still_owner", 32'(grant), 32'(exp_g));
    tick();
    check("drop_guard_grant", 32'(grant), 32'd0);
    check("drop_guard_mvalid", 32'(m_valid), 32'd0);
    check("drop_guard_busy", 32'(busy), 32'd1);
    tick();
    check("drop_idle_grant", 32'(grant), 32'd0);
    check("drop_idle_mvalid", 32'(m_valid), 32'd0);
    tick();
    check("drop_w_grant", 32'(grant), 32'b0100);
    check("drop_w_sel", 32'(sel), 32'd2);

    // Asynchronous reset in the middle of a grant
    din = 8'b11_11_11_11;
    tick();
    tick();
    check("pre_rst_mvalid", 32'(m_valid), 32'd1);
    #2;
    Resetn = 1'b0;
    #1;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_mout", 32'(m_out), 32'd0);
    check("rst_mvalid", 32'(m_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    req = 4'b1001;
    tick();
    Resetn = 1'b1;
    tick();
    check("post_rst_idle", 32'(grant), 32'd0);
    tick();
    check("post_rst_u_grant", 32'(grant), 32'b0001);
    check("post_rst_u_sel", 32'(sel), 32'd0);

    // HOLD_CYCLES=1: one GRANT cycle per owner under contention
    do_reset();
    req = 4'b0011;
    tick();
    tick();
    check("h1_u_grant", 32'(grant1), 32'b0001);
    tick();
    check("h1_guard", 32'(grant1), 32'd0);
    tick();
    check("h1_idle", 32'(grant1), 32'd0);
    tick();
    exp_g = FIXED ? 4'b0001 : 4'b0010;
    check("h1_second_grant", 32'(grant1), 32'(exp_g));
    tick();
    check("h1_guard2", 32'(grant1), 32'd0);
    tick();
    check("h1_idle2", 32'(grant1), 32'd0);
    tick();
    check("h1_third_grant", 32'(grant1), 32'b0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
